// File: rtl/ps2_pkg.sv
// Shared byte constants, decoder states and the key-event record used by the
// PS/2 keyboard decoder and its ASCII lookup.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_PAUSE
  } ps2_state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [7:0] ascii;
  } ps2_evt_t;

endpackage

// File: rtl/ps2_ascii_lut.sv
// Scan-code-set-2 to ASCII translation. Only compiled when PS2_ASCII_EN is
// defined, since the decoder instantiates it only in that build.
`ifdef PS2_ASCII_EN
module ps2_ascii_lut (
  input  logic [7:0] code,
  input  logic       shift,
  output logic [7:0] ascii
);

  // Each entry packs {unshifted, shifted}; keys with no character map to zero.
  logic [15:0] pair;

  always_comb begin
    pair = 16'h0000;
    case (code)
      8'h1C: pair = "aA";
      8'h32: pair = "bB";
      8'h21: pair = "cC";
      8'h23: pair = "dD";
      8'h24: pair = "eE";
      8'h2B: pair = "fF";
      8'h34: pair = "gG";
      8'h33: pair = "hH";
      8'h43: pair = "iI";
      8'h3B: pair = "jJ";
      8'h42: pair = "kK";
      8'h4B: pair = "lL";
      8'h3A: pair = "mM";
      8'h31: pair = "nN";
      8'h44: pair = "oO";
      8'h4D: pair = "pP";
      8'h15: pair = "qQ";
      8'h2D: pair = "rR";
      8'h1B: pair = "sS";
      8'h2C: pair = "tT";
      8'h3C: pair = "uU";
      8'h2A: pair = "vV";
      8'h1D: pair = "wW";
      8'h22: pair = "xX";
      8'h35: pair = "yY";
      8'h1A: pair = "zZ";
      8'h45: pair = "0)";
      8'h16: pair = "1!";
      8'h1E: pair = "2@";
      8'h26: pair = "3#";
      8'h25: pair = "4$";
      8'h2E: pair = "5%";
      8'h36: pair = "6^";
      8'h3D: pair = "7&";
      8'h3E: pair = "8*";
      8'h46: pair = "9(";
      8'h29: pair = "  ";
      8'h0E: pair = "`~";
      8'h4E: pair = "-_";
      8'h55: pair = "=+";
      8'h54: pair = "[{";
      8'h5B: pair = "]}";
      8'h5D: pair = "\\|";
      8'h4C: pair = ";:";
      8'h52: pair = {8'h27, 8'h22};
      8'h41: pair = ",<";
      8'h49: pair = ".>";
      8'h4A: pair = "/?";
      8'h5A: pair = 16'h0D0D;
      8'h0D: pair = 16'h0909;
      8'h66: pair = 16'h0808;
      8'h76: pair = 16'h1B1B;
      default: pair = 16'h0000;
    endcase
  end

  assign ascii = shift ? pair[7:0] : pair[15:8];

endmodule
`endif

// File: rtl/ps2_keyboard_decoder.sv
// Turns PS/2 scancode bytes into key events queued in a registered FWFT FIFO.
// Define PS2_ASCII_EN to build shift tracking and the ASCII translation.
module ps2_keyboard_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk_core,
  input  logic                        rst_core_n,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  input  logic                        rx_error,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [7:0]                  evt_code,
  output logic                        evt_ext,
  output logic                        evt_break,
  output logic [7:0]                  evt_ascii,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  input  logic                        clr_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
`ifdef PS2_ASCII_EN
  localparam int EW = $bits(ps2_evt_t);
`else
  localparam int EW = $bits(ps2_evt_t) - 8;
`endif
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  ps2_state_t     state;
  logic [2:0]     skip_cnt;
  logic           emit;
  logic           emit_ext;
  logic           emit_brk;
  logic [EW-1:0]  wr_data;

  logic [EW-1:0]  mem [FIFO_DEPTH];
  logic [EW-1:0]  head_q;
  logic [EW-1:0]  head_next;
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_next;
  logic [CW-1:0]  count;
  logic [CW-1:0]  count_after_pop;
  logic [CW-1:0]  count_next;
  logic           full;
  logic           pop;
  logic           push;

  // Which byte completes an event, and with which prefix flags, given the state.
  always_comb begin
    emit     = 1'b0;
    emit_ext = 1'b0;
    emit_brk = 1'b0;
    if (rx_valid && !rx_error) begin
      case (state)
        S_IDLE:    emit = (rx_data != PS2_EXT) && (rx_data != PS2_BRK) && (rx_data != PS2_PAUSE);
        S_EXT: begin
          emit     = (rx_data != PS2_BRK) && (rx_data != PS2_EXT);
          emit_ext = 1'b1;
        end
        S_BRK: begin
          emit     = 1'b1;
          emit_brk = 1'b1;
        end
        S_EXT_BRK: begin
          emit     = 1'b1;
          emit_ext = 1'b1;
          emit_brk = 1'b1;
        end
        default: emit = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state    <= S_IDLE;
      skip_cnt <= '0;
    end else if (rx_error) begin
      state    <= S_IDLE;
      skip_cnt <= '0;
    end else if (rx_valid) begin
      case (state)
        S_IDLE: begin
          if (rx_data == PS2_EXT) begin
            state <= S_EXT;
          end else if (rx_data == PS2_BRK) begin
            state <= S_BRK;
          end else if (rx_data == PS2_PAUSE) begin
            state    <= S_PAUSE;
            skip_cnt <= 3'd7;
          end
        end
        S_EXT: begin
          if (rx_data == PS2_BRK) begin
            state <= S_EXT_BRK;
          end else if (rx_data != PS2_EXT) begin
            state <= S_IDLE;
          end
        end
        S_BRK, S_EXT_BRK: state <= S_IDLE;
        S_PAUSE: begin
          skip_cnt <= skip_cnt - 3'd1;
          if (skip_cnt <= 3'd1) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PS2_ASCII_EN
  logic       shift_l;
  logic       shift_r;
  logic [7:0] lut_ascii;
  ps2_evt_t   new_evt;

  ps2_ascii_lut u_ascii_lut (
    .code  (rx_data),
    .shift (shift_l | shift_r),
    .ascii (lut_ascii)
  );

  // ASCII is frozen into the entry now, using the shift state before this byte.
  assign new_evt = '{code: rx_data, ext: emit_ext, brk: emit_brk,
                     ascii: (emit_ext || emit_brk) ? 8'h00 : lut_ascii};
  assign wr_data = new_evt;

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      shift_l <= 1'b0;
      shift_r <= 1'b0;
    end else if (emit && !emit_ext) begin
      if (rx_data == PS2_LSHIFT) shift_l <= !emit_brk;
      if (rx_data == PS2_RSHIFT) shift_r <= !emit_brk;
    end
  end

  assign evt_ascii = head_q[7:0];
`else
  assign wr_data   = {rx_data, emit_ext, emit_brk};
  assign evt_ascii = 8'h00;
`endif

  assign evt_code   = head_q[EW-1 -: 8];
  assign evt_ext    = head_q[EW-9];
  assign evt_break  = head_q[EW-10];
  assign fifo_count = count;

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign full            = (count == DEPTH_C);
  assign pop             = evt_valid && evt_ready;
  assign push            = emit && (!full || pop);
  assign rd_next         = rd_ptr + AW'(pop);
  assign count_after_pop = count - CW'(pop);
  assign count_next      = count_after_pop + CW'(push);

  always_comb begin
    head_next = head_q;
    if (count_next != '0) begin
      if (count_after_pop == '0) begin
        head_next = wr_data;
      end else begin
        head_next = mem[rd_next];
      end
    end
  end

  always_ff @(posedge clk_core) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      head_q    <= '0;
      evt_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      rd_ptr    <= rd_next;
      wr_ptr    <= wr_ptr + AW'(push);
      count     <= count_next;
      head_q    <= head_next;
      evt_valid <= (count_next != '0);
      if (emit && full && !pop) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
// Self-checking bench for ps2_keyboard_decoder: directed scenarios plus random
// key actions checked against a key-level reference model.
module tb_ps2_keyboard_decoder;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef PS2_ASCII_EN
  localparam bit ASCII_ON = 1'b1;
`else
  localparam bit ASCII_ON = 1'b0;
`endif

  // Letters a..z, digits 0..9, then space, matching the strings in model_ascii.
  localparam logic [7:0] KEY_CODES [37] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
    8'h29};

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [7:0] ascii;
  } exp_t;

  logic          clk_core = 1'b0;
  logic          rst_core_n = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_error = 1'b0;
  logic          evt_valid;
  logic          evt_ready = 1'b0;
  logic [7:0]    evt_code;
  logic          evt_ext;
  logic          evt_break;
  logic [7:0]    evt_ascii;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          clr_overflow = 1'b0;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  bit   drv_done;

  ps2_keyboard_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_core     (clk_core),
    .rst_core_n   (rst_core_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_error     (rx_error),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_code     (evt_code),
    .evt_ext      (evt_ext),
    .evt_break    (evt_break),
    .evt_ascii    (evt_ascii),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk_core = ~clk_core;

  function automatic logic [7:0] model_ascii(input logic [7:0] code, input bit shifted);
    string lower_s;
    string upper_s;
    logic [7:0] r;
    lower_s = "abcdefghijklmnopqrstuvwxyz0123456789 ";
    upper_s = "ABCDEFGHIJKLMNOPQRSTUVWXYZ)!@#$%^&*( ";
    r = 8'h00;
    for (int i = 0; i < 37; i++) begin
      if (KEY_CODES[i] == code) r = shifted ? 8'(upper_s[i]) : 8'(lower_s[i]);
    end
    return ASCII_ON ? r : 8'h00;
  endfunction

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk_core);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk_core);
    rx_valid = 1'b0;
  endtask

  task automatic pulseError();
    @(negedge clk_core);
    rx_error = 1'b1;
    @(negedge clk_core);
    rx_error = 1'b0;
  endtask

  task automatic popOne();
    @(negedge clk_core);
    evt_ready = 1'b1;
    @(negedge clk_core);
    evt_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_core_n = 1'b0;
    repeat (3) @(negedge clk_core);
    rst_core_n = 1'b1;
    @(negedge clk_core);
    checks++; if (evt_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_evt_valid got=%b want=0", evt_valid); end
    checks++; if (evt_code !== 8'h00) begin failures++; $display("[TB] FAIL reset_evt_code got=%h want=00", evt_code); end
    checks++; if (evt_ext !== 1'b0) begin failures++; $display("[TB] FAIL reset_evt_ext got=%b want=0", evt_ext); end
    checks++; if (evt_break !== 1'b0) begin failures++; $display("[TB] FAIL reset_evt_break got=%b want=0", evt_break); end
    checks++; if (evt_ascii !== 8'h00) begin failures++; $display("[TB] FAIL reset_evt_ascii got=%h want=00", evt_ascii); end
    checks++; if (fifo_count !== CW'(0)) begin failures++; $display("[TB] FAIL reset_fifo_count got=%0d want=0", fifo_count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow got=%b want=0", overflow); end
  endtask

  task automatic test_make();
    logic [7:0] want_ascii;
    want_ascii = ASCII_ON ? 8'h61 : 8'h00;
    applyStimulus(8'h1C);
    checks++; if (fifo_count !== CW'(1)) begin failures++; $display("[TB] FAIL make_count got=%0d want=1", fifo_count); end
    checks++; if (evt_valid !== 1'b1) begin failures++; $display("[TB] FAIL make_latency evt_valid got=%b want=1", evt_valid); end
    checks++;
    if ({evt_code, evt_ext, evt_break, evt_ascii} !== {8'h1C, 1'b0, 1'b0, want_ascii}) begin
      failures++; $display("[TB] FAIL make_event got=%h/%b/%b/%h want=1c/0/0/%h", evt_code, evt_ext, evt_break, evt_ascii, want_ascii);
    end
    popOne();
    checks++; if (evt_valid !== 1'b0) begin failures++; $display("[TB] FAIL make_pop evt_valid got=%b want=0", evt_valid); end
  endtask

  task automatic test_ext_break();
    applyStimulus(8'hE0);
    applyStimulus(8'hF0);
    checks++; if (fifo_count !== CW'(0)) begin failures++; $display("[TB] FAIL extbrk_prefix_count got=%0d want=0", fifo_count); end
    applyStimulus(8'h75);
    checks++; if (fifo_count !== CW'(1)) begin failures++; $display("[TB] FAIL extbrk_count got=%0d want=1", fifo_count); end
    checks++;
    if ({evt_code, evt_ext, evt_break, evt_ascii} !== {8'h75, 1'b1, 1'b1, 8'h00}) begin
      failures++; $display("[TB] FAIL extbrk_event got=%h/%b/%b/%h want=75/1/1/00", evt_code, evt_ext, evt_break, evt_ascii);
    end
    popOne();
  endtask

  task automatic test_shift();
    exp_t want [4];
    want[0] = '{8'h12, 1'b0, 1'b0, 8'h00};
    want[1] = '{8'h1C, 1'b0, 1'b0, ASCII_ON ? 8'h41 : 8'h00};
    want[2] = '{8'h12, 1'b0, 1'b1, 8'h00};
    want[3] = '{8'h1C, 1'b0, 1'b0, ASCII_ON ? 8'h61 : 8'h00};
    applyStimulus(8'h12);
    applyStimulus(8'h1C);
    applyStimulus(8'hF0);
    applyStimulus(8'h12);
    applyStimulus(8'h1C);
    checks++; if (fifo_count !== CW'(4)) begin failures++; $display("[TB] FAIL shift_count got=%0d want=4", fifo_count); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({evt_valid, evt_code, evt_ext, evt_break, evt_ascii} !== {1'b1, want[i].code, want[i].ext, want[i].brk, want[i].ascii}) begin
        failures++;
        $display("[TB] FAIL shift_event%0d got=%b/%h/%b/%b/%h want=1/%h/%b/%b/%h", i, evt_valid, evt_code, evt_ext, evt_break,
                 evt_ascii, want[i].code, want[i].ext, want[i].brk, want[i].ascii);
      end
      popOne();
    end
  endtask

  task automatic test_overflow();
    logic [7:0] want_code;
    for (int i = 0; i < 9; i++) applyStimulus(KEY_CODES[i]);
    checks++; if (fifo_count !== CW'(DEPTH)) begin failures++; $display("[TB] FAIL ovf_count got=%0d want=%0d", fifo_count, DEPTH); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_flag got=%b want=1", overflow); end
    checks++; if (evt_code !== KEY_CODES[0]) begin failures++; $display("[TB] FAIL ovf_head got=%h want=%h", evt_code, KEY_CODES[0]); end
    @(negedge clk_core);
    evt_ready = 1'b1;
    rx_data   = KEY_CODES[9];
    rx_valid  = 1'b1;
    @(negedge clk_core);
    evt_ready = 1'b0;
    rx_valid  = 1'b0;
    checks++; if (fifo_count !== CW'(DEPTH)) begin failures++; $display("[TB] FAIL ovf_pushpop_count got=%0d want=%0d", fifo_count, DEPTH); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_pushpop_flag got=%b want=1", overflow); end
    checks++; if (evt_code !== KEY_CODES[1]) begin failures++; $display("[TB] FAIL ovf_pushpop_head got=%h want=%h", evt_code, KEY_CODES[1]); end
    @(negedge clk_core);
    clr_overflow = 1'b1;
    @(negedge clk_core);
    clr_overflow = 1'b0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL ovf_clear got=%b want=0", overflow); end
    for (int i = 1; i <= DEPTH; i++) begin
      want_code = (i == DEPTH) ? KEY_CODES[9] : KEY_CODES[i];
      checks++;
      if ({evt_valid, evt_code} !== {1'b1, want_code}) begin
        failures++; $display("[TB] FAIL ovf_drain%0d got=%b/%h want=1/%h", i, evt_valid, evt_code, want_code);
      end
      popOne();
    end
    checks++; if (fifo_count !== CW'(0)) begin failures++; $display("[TB] FAIL ovf_empty got=%0d want=0", fifo_count); end
  endtask

  task automatic test_error();
    logic [7:0] want_ascii;
    logic [7:0] pause_tail [7];
    want_ascii = ASCII_ON ? 8'h61 : 8'h00;
    pause_tail = '{8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    applyStimulus(8'hF0);
    pulseError();
    applyStimulus(8'h1C);
    checks++; if (fifo_count !== CW'(1)) begin failures++; $display("[TB] FAIL err_count got=%0d want=1", fifo_count); end
    checks++;
    if ({evt_code, evt_ext, evt_break, evt_ascii} !== {8'h1C, 1'b0, 1'b0, want_ascii}) begin
      failures++; $display("[TB] FAIL err_event got=%h/%b/%b/%h want=1c/0/0/%h", evt_code, evt_ext, evt_break, evt_ascii, want_ascii);
    end
    popOne();
    applyStimulus(8'hE0);
    @(negedge clk_core);
    rx_data  = 8'h1C;
    rx_valid = 1'b1;
    rx_error = 1'b1;
    @(negedge clk_core);
    rx_valid = 1'b0;
    rx_error = 1'b0;
    checks++; if (fifo_count !== CW'(0)) begin failures++; $display("[TB] FAIL err_wins_count got=%0d want=0", fifo_count); end
    applyStimulus(8'h1C);
    checks++;
    if ({evt_valid, evt_code, evt_ext, evt_break} !== {1'b1, 8'h1C, 1'b0, 1'b0}) begin
      failures++; $display("[TB] FAIL err_wins_event got=%b/%h/%b/%b want=1/1c/0/0", evt_valid, evt_code, evt_ext, evt_break);
    end
    popOne();
    applyStimulus(8'hE1);
    for (int i = 0; i < 7; i++) applyStimulus(pause_tail[i]);
    checks++; if (fifo_count !== CW'(0)) begin failures++; $display("[TB] FAIL pause_count got=%0d want=0", fifo_count); end
    applyStimulus(8'h1C);
    checks++;
    if ({fifo_count, evt_code, evt_ext, evt_break} !== {CW'(1), 8'h1C, 1'b0, 1'b0}) begin
      failures++; $display("[TB] FAIL pause_next got=%0d/%h/%b/%b want=1/1c/0/0", fifo_count, evt_code, evt_ext, evt_break);
    end
    popOne();
  endtask

  task automatic test_reset_mid();
    applyStimulus(8'h1C);
    applyStimulus(8'h32);
    applyStimulus(8'h21);
    applyStimulus(8'hE0);
    checks++; if (fifo_count !== CW'(3)) begin failures++; $display("[TB] FAIL rstmid_pre_count got=%0d want=3", fifo_count); end
    @(negedge clk_core);
    rst_core_n = 1'b0;
    #1;
    checks++;
    if ({evt_valid, evt_code, evt_ext, evt_break, evt_ascii, fifo_count, overflow} !== {1'b0, 8'h00, 1'b0, 1'b0, 8'h00, CW'(0), 1'b0}) begin
      failures++;
      $display("[TB] FAIL rstmid_outputs got=%b/%h/%b/%b/%h/%0d/%b want=all zero", evt_valid, evt_code, evt_ext, evt_break,
               evt_ascii, fifo_count, overflow);
    end
    @(negedge clk_core);
    rst_core_n = 1'b1;
    applyStimulus(8'h1C);
    checks++;
    if ({fifo_count, evt_code, evt_ext, evt_break} !== {CW'(1), 8'h1C, 1'b0, 1'b0}) begin
      failures++; $display("[TB] FAIL rstmid_next got=%0d/%h/%b/%b want=1/1c/0/0", fifo_count, evt_code, evt_ext, evt_break);
    end
    popOne();
  endtask

  task automatic test_random();
    bit   timed_out;
    bit   shift_l;
    bit   shift_r;
    exp_t e;
    drv_done  = 1'b0;
    timed_out = 1'b1;
    shift_l   = 1'b0;
    shift_r   = 1'b0;
    exp_q.delete();
    fork
      begin
        for (int n = 0; n < 150; n++) begin
          int kind;
          int idx;
          logic [7:0] code;
          bit ext;
          bit brk;
          kind = $urandom_range(0, 19);
          if (kind == 0) begin
            applyStimulus(8'hE1); applyStimulus(8'h14); applyStimulus(8'h77); applyStimulus(8'hE1);
            applyStimulus(8'hF0); applyStimulus(8'h14); applyStimulus(8'hF0); applyStimulus(8'h77);
          end else if (kind == 1) begin
            applyStimulus(($urandom_range(0, 1) == 1) ? 8'hE0 : 8'hF0);
            pulseError();
          end else begin
            idx  = $urandom_range(0, 39);
            code = (idx < 37) ? KEY_CODES[idx] : (idx == 37) ? 8'h12 : (idx == 38) ? 8'h59 : 8'h05;
            ext  = ($urandom_range(0, 3) == 0);
            brk  = ($urandom_range(0, 1) == 1);
            e.code  = code;
            e.ext   = ext;
            e.brk   = brk;
            e.ascii = (ext || brk) ? 8'h00 : model_ascii(code, shift_l || shift_r);
            if (ext) applyStimulus(8'hE0);
            if (brk) applyStimulus(8'hF0);
            exp_q.push_back(e);
            applyStimulus(code);
            if (!ext && code == 8'h12) shift_l = !brk;
            if (!ext && code == 8'h59) shift_r = !brk;
          end
          repeat ($urandom_range(0, 3)) @(negedge clk_core);
        end
        drv_done = 1'b1;
      end
      begin
        for (int cyc = 0; cyc < 20000; cyc++) begin
          bit r;
          exp_t h;
          @(negedge clk_core);
          if (drv_done && exp_q.size() == 0 && evt_valid === 1'b0) begin
            timed_out = 1'b0;
            break;
          end
          r = ($urandom_range(0, 3) != 0);
          if (r && evt_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
              failures++; $display("[TB] FAIL rand_unexpected got=%h/%b/%b/%h want=no event", evt_code, evt_ext, evt_break, evt_ascii);
            end else begin
              h = exp_q.pop_front();
              if ({evt_code, evt_ext, evt_break, evt_ascii} !== {h.code, h.ext, h.brk, h.ascii}) begin
                failures++;
                $display("[TB] FAIL rand_event got=%h/%b/%b/%h want=%h/%b/%b/%h", evt_code, evt_ext, evt_break, evt_ascii,
                         h.code, h.ext, h.brk, h.ascii);
              end
            end
          end
          evt_ready = r;
        end
        evt_ready = 1'b0;
      end
    join
    checks++; if (timed_out) begin failures++; $display("[TB] FAIL rand_timeout got=%0d pending want=0", exp_q.size()); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL rand_overflow got=%b want=0", overflow); end
    checks++; if (fifo_count !== CW'(0)) begin failures++; $display("[TB] FAIL rand_final_count got=%0d want=0", fifo_count); end
  endtask

  initial begin
    test_reset();
    test_make();
    test_ext_break();
    test_shift();
    test_overflow();
    test_error();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
